imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
Write-side initiator for the instruction/data memory arrays. Accepts a byte stream (program image) over a valid/ready handshake, assembles little-endian 32-bit words, and drives the memory write port (we, Addr, DataIn) one word per write strobe. Sits between the host/UART byte source and the memory during boot. Signals the rest of the CPU when the image is fully loaded.

Parameters:
BASE_ADDR, 0, memory address of the first word written
ADDR_STEP, 1, address increment per word (memory indexes by word; 4 for byte-addressed targets)
MAX_WORDS, 61, largest accepted word count (instruction memory depth)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  begin a load; sampled only in IDLE, DONE, ERR
byte_valid  input  1  byte_data holds a valid byte
byte_data  input  8  stream byte
byte_ready  output  1  loader accepts byte this cycle
mem_we  output  1  memory write enable, one-cycle pulse per word
mem_addr  output  32  memory address
mem_data  output  32  memory write data
busy  output  1  load in progress (HDR, DATA, WRITE, CHK)
done  output  1  image loaded successfully; held
error  output  1  load aborted; held

Behaviour:
- Clock clk; reset synchronous, active-high. On reset: state IDLE, all outputs 0, byte/word counters 0, mem_addr = 0.
- Byte transfer occurs on a rising edge where byte_valid && byte_ready. byte_ready is combinational from state: 1 in HDR, DATA, CHK; 0 elsewhere. byte_data is ignored without a transfer.
- Stream format: 4-byte word count N (little-endian), then N words of 4 bytes each (little-endian: first byte -> bits 7:0).
- States:
  IDLE: start=1 -> HDR, clear counters.
  HDR: collect 4 bytes. After the 4th: N > MAX_WORDS -> ERR with no writes; N = 0 -> CHK (macro on) or DONE; else -> DATA.
  DATA: collect 4 bytes into a shift register. After the 4th -> WRITE.
  WRITE: exactly one cycle. mem_we=1, mem_addr = BASE_ADDR + i*ADDR_STEP (i = word index from 0, 32-bit wrap), mem_data = assembled word. Then i+1 == N -> CHK/DONE; else -> DATA.
  DONE: done=1, busy=0. start=1 -> HDR (done cleared the same edge).
  ERR: error=1, busy=0. Only start or reset leaves, start -> HDR.
- mem_we is 0 in every state except WRITE. mem_addr/mem_data hold last written values outside WRITE.
- Best-case throughput: 5 cycles per word (4 byte cycles + 1 WRITE). Byte stalls (byte_valid=0) extend the current state indefinitely with no timeout.
- start while busy is ignored. byte_valid in IDLE/DONE/ERR is not accepted (ready=0).
- Reset mid-load: next edge -> IDLE, mem_we=0. Words already written stay in memory.
- Internal counters: byte index 2 bits; word index 32 bits, compared with N using full 32 bits.

Optional Feature:
IMEM_LOADER_CHECKSUM_EN: when defined, after the last word (or immediately after a header with N=0) the loader enters CHK and collects a 4-byte little-endian checksum equal to the XOR of all N data words (0 for N=0). Match -> DONE; mismatch -> ERR. Writes already performed are not undone. When undefined, the CHK state does not exist: the last WRITE (or N=0 header) goes directly to DONE, and no checksum bytes are consumed.

Test Plan:
- reset, start, stream 02 00 00 00 | 13 00 00 00 | EF BE AD DE, byte_valid held 1 -> exactly two mem_we pulses: addr 0 data 0x00000013, addr 1 data 0xDEADBEEF; done=1 after the 2nd write (plus CHK bytes 0xDEADBEFC when the macro is defined).
- Header N=62 (3E 00 00 00) with MAX_WORDS=61 -> error=1 after the 4th byte, mem_we never asserted, byte_ready=0.
- Same 2-word image with byte_valid toggling 1/0 each cycle -> identical writes; WRITE pulses are exactly one cycle wide; byte_ready=0 during WRITE.
- Assert reset after 6 bytes of a 3-word load -> outputs return to 0 next edge; a new start with N=1, word 0x00000001 writes addr 0 and sets done.
- (macro on) N=1, word 0x12345678, checksum 0x12345679 -> one write to addr 0, then error=1, done=0; a new start with the correct checksum -> done=1.
- Header N=0 -> no writes; done=1 immediately (macro off) or after checksum 00 00 00 00 (macro on).

Source files
------------

// File: rtl/imem_loader.sv
// Boot-time image loader: byte stream -> little-endian words -> memory write port.
// Optional checksum trailer enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'd0,
  parameter logic [31:0] ADDR_STEP = 32'd1,
  parameter logic [31:0] MAX_WORDS = 32'd61
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_DATA, S_WRITE, S_DONE, S_ERR
`ifdef IMEM_LOADER_CHECKSUM_EN
    , S_CHK
`endif
  } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t S_FIN = S_CHK;
`else
  localparam state_t S_FIN = S_DONE;
`endif

  state_t      state, next;
  logic [1:0]  bidx;
  logic [31:0] widx;
  logic [31:0] nwords;
  logic [31:0] waddr;
  logic [23:0] shreg;
  logic [31:0] word_full;
  logic        xfer;
  logic        last;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] csum;
`endif

  // newest byte lands in the top lane, so the first byte ends up in bits 7:0
  assign word_full = {byte_data, shreg};
  assign xfer      = byte_valid && byte_ready;
  assign last      = xfer && (bidx == 2'd3);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next;
  end

  always_comb begin
    next       = state;
    byte_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    mem_we     = 1'b0;
    case (state)
      S_IDLE: if (start) next = S_HDR;
      S_HDR: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (last) begin
          if (word_full > MAX_WORDS) next = S_ERR;
          else if (word_full == '0)  next = S_FIN;
          else                       next = S_DATA;
        end
      end
      S_DATA: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (last) next = S_WRITE;
      end
      S_WRITE: begin
        busy   = 1'b1;
        mem_we = 1'b1;
        next   = (widx + 32'd1 == nwords) ? S_FIN : S_DATA;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (last) next = (word_full == csum) ? S_DONE : S_ERR;
      end
`endif
      S_DONE: begin
        done = 1'b1;
        if (start) next = S_HDR;
      end
      S_ERR: begin
        error = 1'b1;
        if (start) next = S_HDR;
      end
      default: next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bidx     <= '0;
      widx     <= '0;
      nwords   <= '0;
      waddr    <= '0;
      shreg    <= '0;
      mem_addr <= '0;
      mem_data <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum     <= '0;
`endif
    end else begin
      if ((state == S_IDLE || state == S_DONE || state == S_ERR) && start) begin
        bidx  <= '0;
        widx  <= '0;
        waddr <= BASE_ADDR;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum  <= '0;
`endif
      end
      if (xfer) begin
        shreg <= word_full[31:8];
        bidx  <= bidx + 2'd1;
      end
      if (state == S_HDR && last) nwords <= word_full;
      // address/data latch on entry to WRITE and then hold until the next word
      if (state == S_DATA && last) begin
        mem_data <= word_full;
        mem_addr <= waddr;
      end
      if (state == S_WRITE) begin
        widx  <= widx + 32'd1;
        waddr <= waddr + ADDR_STEP;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum  <= csum ^ mem_data;
`endif
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed image cases plus randomized loads
// compared against a stream-level reference model.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset, start, byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready, mem_we, busy, done, error;
  logic [31:0] mem_addr, mem_data;

  imem_loader #(.BASE_ADDR(32'd0), .ADDR_STEP(32'd1), .MAX_WORDS(32'd61)) dut (
    .clk(clk), .reset(reset), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_data(mem_data), .busy(busy), .done(done),
    .error(error)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [7:0]  stream[$];
  logic [63:0] exp_w[$];
  logic [63:0] got_w[$];
  bit          exp_done, exp_err;
  int          exp_used;
  logic        prev_we = 1'b0;

  always @(negedge clk) begin
    if (mem_we) begin
      check("we_width", {63'd0, prev_we}, 64'd0);
      check("rdy_in_write", {63'd0, byte_ready}, 64'd0);
      got_w.push_back({mem_addr, mem_data});
    end
    prev_we <= mem_we;
  end

  function automatic logic [31:0] word_at(input int p);
    return {stream[p+3], stream[p+2], stream[p+1], stream[p]};
  endfunction

  task automatic push_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) stream.push_back(w[8*b +: 8]);
  endtask

  // Reference: interpret the stream by its format rules.
  task automatic build_model();
    logic [31:0] n, x;
    exp_w.delete();
    exp_done = 0;
    exp_err  = 0;
    x = '0;
    n = word_at(0);
    if (n > 32'd61) begin
      exp_err  = 1;
      exp_used = 4;
    end else begin
      for (int i = 0; i < int'(n); i++) begin
        exp_w.push_back({32'(i), word_at(4 + 4*i)});
        x = x ^ word_at(4 + 4*i);
      end
      exp_used = 4 + 4*int'(n);
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (word_at(exp_used) == x) exp_done = 1;
      else                        exp_err  = 1;
      exp_used += 4;
`else
      exp_done = 1;
`endif
    end
  endtask

  task automatic gen_stream(input logic [31:0] n, input bit bad);
    logic [31:0] w, x;
    stream.delete();
    push_word(n);
    x = '0;
    if (n <= 32'd61) begin
      for (int i = 0; i < int'(n); i++) begin
        w = $urandom;
        push_word(w);
        x = x ^ w;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      push_word(bad ? (x ^ (32'd1 << $urandom_range(0, 31))) : x);
`endif
    end
  endtask

  // mode: 0 = valid always, 1 = toggle, 2 = random gaps
  task automatic run_load(input int mode, input string tag);
    int p = 0;
    int cyc = 0;
    bit tog = 1;
    bit v;
    build_model();
    got_w.delete();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check({tag, "_busy"}, {63'd0, busy}, 64'd1);
    while (!(done || error) && cyc < 3000) begin
      if (p < stream.size()) begin
        case (mode)
          0:       v = 1;
          1:       begin v = tog; tog = !tog; end
          default: v = ($urandom_range(0, 2) != 0);
        endcase
      end else v = 0;
      byte_valid = v;
      byte_data  = v ? stream[p] : 8'($urandom);
      #1;
      if (v && byte_ready) p++;
      @(negedge clk);
      cyc++;
    end
    byte_valid = 1'b0;
    check({tag, "_nohang"}, {63'd0, cyc < 3000}, 64'd1);
    check({tag, "_done"}, {63'd0, done}, {63'd0, exp_done});
    check({tag, "_error"}, {63'd0, error}, {63'd0, exp_err});
    check({tag, "_idle_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_idle_rdy"}, {63'd0, byte_ready}, 64'd0);
    check({tag, "_consumed"}, 64'(p), 64'(exp_used));
    check({tag, "_nwrites"}, 64'(got_w.size()), 64'(exp_w.size()));
    for (int i = 0; i < got_w.size() && i < exp_w.size(); i++)
      check({tag, "_write"}, got_w[i], exp_w[i]);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_we"},   {63'd0, mem_we}, 64'd0);
    check({tag, "_done"}, {63'd0, done}, 64'd0);
    check({tag, "_err"},  {63'd0, error}, 64'd0);
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_rdy"},  {63'd0, byte_ready}, 64'd0);
    check({tag, "_addr"}, {32'd0, mem_addr}, 64'd0);
    check({tag, "_data"}, {32'd0, mem_data}, 64'd0);
  endtask

  initial begin
    int p, cyc;
    reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = '0;
    repeat (3) @(negedge clk);
    check_zero("rst");
    reset = 1'b0;

    stream = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
               8'hEF, 8'hBE, 8'hAD, 8'hDE};
`ifdef IMEM_LOADER_CHECKSUM_EN
    push_word(32'hDEADBEFC);
`endif
    run_load(0, "two_word");
    run_load(1, "two_word_tog");

    stream = '{8'h3E, 8'h00, 8'h00, 8'h00};
    run_load(0, "n62");
    stream = '{8'h02, 8'h00, 8'h01, 8'h00};
    run_load(2, "n_hi16");

    stream = '{8'h00, 8'h00, 8'h00, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
    push_word(32'h0);
`endif
    run_load(0, "n0");

    // reset six bytes into a three-word load
    gen_stream(32'd3, 0);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    p = 0; cyc = 0;
    while (p < 6 && cyc < 100) begin
      byte_valid = 1'b1;
      byte_data  = stream[p];
      #1;
      if (byte_ready) p++;
      @(negedge clk);
      cyc++;
    end
    byte_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check_zero("midrst");
    reset = 1'b0;
    stream = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
    push_word(32'h1);
`endif
    run_load(2, "after_rst");

`ifdef IMEM_LOADER_CHECKSUM_EN
    stream.delete();
    push_word(32'd1); push_word(32'h12345678); push_word(32'h12345679);
    run_load(0, "bad_csum");
    stream.delete();
    push_word(32'd1); push_word(32'h12345678); push_word(32'h12345678);
    run_load(0, "good_csum");
`endif

    for (int t = 0; t < 25; t++) begin
      logic [31:0] n;
      n = ($urandom_range(0, 9) == 0) ? 32'd62 + 32'($urandom_range(0, 70000))
                                      : 32'($urandom_range(0, 6));
      gen_stream(n, $urandom_range(0, 3) == 0);
      run_load($urandom_range(0, 2), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
